// File: rtl/wb_merge.sv
// Writeback merge: arbitrates ALU results and queued LSU/MDU results onto one registered
// register-file write port, killing stale queued writes on same-register WAW.
module wb_merge #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            wb_stall,
  output logic [31:0]     pend_mask,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - 1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [AW-1:0]   head_r, tail_r;
  logic [CW-1:0]   count_r, count_nxt_s;
  logic [DEPTH-1:0] live_r, live_nxt_s;
  logic [4:0]      rd_r   [DEPTH];
  logic [XLEN-1:0] data_r [DEPTH];

  logic            rf_we_r, stall_r;
  logic [4:0]      rf_waddr_r;
  logic [XLEN-1:0] rf_wdata_r;

  logic            lsu_ready_s, acc_s, alu_win_s, empty_s, head_live_s;
  logic            pop_s, bypass_s, enq_s, sel_s;
  logic [4:0]      sel_rd_s;
  logic [XLEN-1:0] sel_data_s;
  logic [31:0]     pend_s;

  assign lsu_ready_s = (count_r != FULL_CNT);
  assign empty_s     = (count_r == {CW{1'b0}});

  // Arbitration: ALU > queue head (live writes, killed pops silently) > empty-queue bypass.
  always_comb begin
    acc_s       = lsu_valid && lsu_ready_s;
    alu_win_s   = alu_valid && (alu_rd != 5'd0);
    head_live_s = !empty_s && live_r[head_r];
    pop_s       = !alu_win_s && !empty_s;
    bypass_s    = !alu_win_s && empty_s && acc_s && (lsu_rd != 5'd0);
    enq_s       = acc_s && (lsu_rd != 5'd0) && !bypass_s;
    sel_s       = 1'b0;
    sel_rd_s    = 5'd0;
    sel_data_s  = {XLEN{1'b0}};
    if (alu_win_s) begin
      sel_s      = 1'b1;
      sel_rd_s   = alu_rd;
      sel_data_s = alu_data;
    end else if (pop_s && head_live_s) begin
      sel_s      = 1'b1;
      sel_rd_s   = rd_r[head_r];
      sel_data_s = data_r[head_r];
    end else if (bypass_s) begin
      sel_s      = 1'b1;
      sel_rd_s   = lsu_rd;
      sel_data_s = lsu_data;
    end else begin
      sel_s      = 1'b0;
    end
    count_nxt_s = count_r + CW'(enq_s) - CW'(pop_s);
  end

  // Live bits: WAW kill on ALU win, cleared on pop, set on enqueue; pending mask from live entries.
  always_comb begin
    live_nxt_s = live_r;
    pend_s     = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      live_nxt_s[i] = (alu_win_s && (rd_r[i] == alu_rd)) ? 1'b0 : live_r[i];
      pend_s        = pend_s | (live_r[i] ? (32'd1 << rd_r[i]) : 32'd0);
    end
    live_nxt_s[head_r] = pop_s ? 1'b0 : live_nxt_s[head_r];
    live_nxt_s[tail_r] = enq_s ? 1'b1 : live_nxt_s[tail_r];
  end

  // Queue state: pointers, occupancy, entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
      live_r  <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        rd_r[i]   <= 5'd0;
        data_r[i] <= {XLEN{1'b0}};
      end
    end else begin
      count_r <= count_nxt_s;
      live_r  <= live_nxt_s;
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      if (enq_s) begin
        tail_r         <= tail_r + PTR_ONE;
        rd_r[tail_r]   <= lsu_rd;
        data_r[tail_r] <= lsu_data;
      end
    end
  end

  // Registered write port and stall; address/data hold on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= 5'd0;
      rf_wdata_r <= {XLEN{1'b0}};
      stall_r    <= 1'b0;
    end else begin
      rf_we_r <= sel_s;
      stall_r <= (count_nxt_s >= STALL_CNT);
      if (sel_s) begin
        rf_waddr_r <= sel_rd_s;
        rf_wdata_r <= sel_data_s;
      end
    end
  end

  assign lsu_ready = lsu_ready_s;
  assign pend_mask = pend_s;
  assign wb_stall  = stall_r;
  assign rf_we     = rf_we_r;
  assign rf_waddr  = rf_waddr_r;
  assign rf_wdata  = rf_wdata_r;
endmodule

// File: tb/tb_wb_merge.sv
// Bench for wb_merge: directed vector table, hand sequences and random traffic
// checked against a queue-level reference model.
module tb_wb_merge;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            alu_valid = 1'b0, lsu_valid = 1'b0;
  logic [4:0]      alu_rd = 5'd0, lsu_rd = 5'd0;
  logic [XLEN-1:0] alu_data = 32'd0, lsu_data = 32'd0;
  logic            lsu_ready, wb_stall, rf_we;
  logic [31:0]     pend_mask;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  always #5 clk = ~clk;

  wb_merge #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .wb_stall(wb_stall), .pend_mask(pend_mask),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [4:0] rd; logic [31:0] data; logic live; } ent_t;
  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic        m_stall;

  function automatic logic [31:0] m_pend();
    logic [31:0] p = 32'd0;
    foreach (mq[i]) if (mq[i].live) p[mq[i].rd] = 1'b1;
    return p;
  endfunction

  task automatic m_clear();
    mq.delete();
    m_we = 1'b0; m_wa = 5'd0; m_wd = 32'd0; m_stall = 1'b0;
  endtask

  task automatic m_check(input string tag);
    logic rdy_exp = (mq.size() != DEPTH);
    chk({tag, "_we"},    {31'd0, rf_we}, {31'd0, m_we});
    if (m_we) begin
      chk({tag, "_waddr"}, {27'd0, rf_waddr}, {27'd0, m_wa});
      chk({tag, "_wdata"}, rf_wdata, m_wd);
    end
    chk({tag, "_pend"},  pend_mask, m_pend());
    chk({tag, "_ready"}, {31'd0, lsu_ready}, {31'd0, rdy_exp});
    chk({tag, "_stall"}, {31'd0, wb_stall}, {31'd0, m_stall});
  endtask

  // One cycle: check current outputs, drive inputs, advance model and DUT.
  task automatic mstep(input string tag, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld, output logic accepted);
    logic rdy, acc, byp, sel;
    ent_t e;
    m_check(tag);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    lsu_valid = lv; lsu_rd = lr; lsu_data = ld;
    rdy = (mq.size() != DEPTH);
    acc = lv && rdy;
    byp = 1'b0;
    sel = 1'b0;
    if (av && ar != 5'd0) begin
      sel = 1'b1; m_wa = ar; m_wd = ad;
      foreach (mq[i]) if (mq[i].rd == ar) mq[i].live = 1'b0;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      if (e.live) begin sel = 1'b1; m_wa = e.rd; m_wd = e.data; end
    end else if (acc && lr != 5'd0) begin
      byp = 1'b1; sel = 1'b1; m_wa = lr; m_wd = ld;
    end
    if (acc && lr != 5'd0 && !byp) mq.push_back('{lr, ld, 1'b1});
    m_we = sel;
    m_stall = (mq.size() >= DEPTH - 1);
    accepted = acc;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    alu_valid = 1'b0; lsu_valid = 1'b0;
    alu_rd = 5'd0; lsu_rd = 5'd0; alu_data = 32'd0; lsu_data = 32'd0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    m_clear();
    @(posedge clk); #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic av; logic [4:0] ar; logic [31:0] ad;
    logic lv; logic [4:0] lr; logic [31:0] ld;
    logic we; logic [4:0] wa; logic [31:0] wd;
    logic [31:0] pend; logic rdy; logic stall; logic [2:0] cnt;
  } row_t;

  function automatic row_t mk(logic av, logic [4:0] ar, logic [31:0] ad,
                              logic lv, logic [4:0] lr, logic [31:0] ld,
                              logic we, logic [4:0] wa, logic [31:0] wd,
                              logic [31:0] pend, logic rdy, logic stall, logic [2:0] cnt);
    row_t r;
    r.av = av; r.ar = ar; r.ad = ad; r.lv = lv; r.lr = lr; r.ld = ld;
    r.we = we; r.wa = wa; r.wd = wd; r.pend = pend; r.rdy = rdy; r.stall = stall; r.cnt = cnt;
    return r;
  endfunction

  row_t tbl[14];
  logic acc_o;
  int   n_acc;

  initial begin
    // idle bypass
    tbl[0]  = mk(1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1, 5'd7, 32'hDEAD_BEEF, 32'h0,  1'b1, 1'b0, 3'd0);
    // ALU priority over queued LSU results
    tbl[1]  = mk(1'b1, 5'd9, 32'h99,   1'b1, 5'd3, 32'h11,   1'b1, 5'd9, 32'h99,   32'h08, 1'b1, 1'b0, 3'd1);
    tbl[2]  = mk(1'b1, 5'd9, 32'h99,   1'b1, 5'd4, 32'h22,   1'b1, 5'd9, 32'h99,   32'h18, 1'b1, 1'b0, 3'd2);
    tbl[3]  = mk(1'b1, 5'd9, 32'h99,   1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 32'h99,   32'h18, 1'b1, 1'b0, 3'd2);
    tbl[4]  = mk(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd3, 32'h11,   32'h10, 1'b1, 1'b0, 3'd1);
    tbl[5]  = mk(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd4, 32'h22,   32'h0,  1'b1, 1'b0, 3'd0);
    tbl[6]  = mk(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd4, 32'h22,   32'h0,  1'b1, 1'b0, 3'd0);
    // WAW kill
    tbl[7]  = mk(1'b1, 5'd1, 32'h1,    1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd1, 32'h1,    32'h20, 1'b1, 1'b0, 3'd1);
    tbl[8]  = mk(1'b1, 5'd5, 32'hBBBB, 1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 32'hBBBB, 32'h0,  1'b1, 1'b0, 3'd1);
    tbl[9]  = mk(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd5, 32'hBBBB, 32'h0,  1'b1, 1'b0, 3'd0);
    tbl[10] = mk(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd5, 32'hBBBB, 32'h0,  1'b1, 1'b0, 3'd0);
    // x0 discard, and ALU rd 0 not blocking a pop
    tbl[11] = mk(1'b1, 5'd0, 32'h55,   1'b1, 5'd0, 32'h66,   1'b0, 5'd5, 32'hBBBB, 32'h0,  1'b1, 1'b0, 3'd0);
    tbl[12] = mk(1'b1, 5'd1, 32'h7,    1'b1, 5'd2, 32'h33,   1'b1, 5'd1, 32'h7,    32'h04, 1'b1, 1'b0, 3'd1);
    tbl[13] = mk(1'b1, 5'd0, 32'h99,   1'b0, 5'd0, 32'h0,    1'b1, 5'd2, 32'h33,   32'h0,  1'b1, 1'b0, 3'd0);

    do_reset();
    chk("rst_we",    {31'd0, rf_we}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_pend",  pend_mask, 32'd0);
    chk("rst_ready", {31'd0, lsu_ready}, 32'd1);
    chk("rst_stall", {31'd0, wb_stall}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      alu_valid = tbl[i].av; alu_rd = tbl[i].ar; alu_data = tbl[i].ad;
      lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lr; lsu_data = tbl[i].ld;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_we", i),    {31'd0, rf_we}, {31'd0, tbl[i].we});
      chk($sformatf("vec%0d_waddr", i), {27'd0, rf_waddr}, {27'd0, tbl[i].wa});
      chk($sformatf("vec%0d_wdata", i), rf_wdata, tbl[i].wd);
      chk($sformatf("vec%0d_pend", i),  pend_mask, tbl[i].pend);
      chk($sformatf("vec%0d_ready", i), {31'd0, lsu_ready}, {31'd0, tbl[i].rdy});
      chk($sformatf("vec%0d_stall", i), {31'd0, wb_stall}, {31'd0, tbl[i].stall});
      chk($sformatf("vec%0d_count", i), {29'd0, dut.count_r}, {29'd0, tbl[i].cnt});
    end

    // full / back-pressure: ALU holds the port while DEPTH+2 LSU results are offered
    do_reset();
    n_acc = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      mstep("full", 1'b1, 5'd1, 32'h1000 + i, 1'b1, 5'(10 + i), 32'h100 + i, acc_o);
      if (acc_o) n_acc++;
      if (i == 2) chk("full_stall_at3", {31'd0, wb_stall}, 32'd1);
      if (i >= 3) chk("full_ready_low", {31'd0, lsu_ready}, 32'd0);
    end
    chk("full_accepted", n_acc, DEPTH);
    mstep("drain0", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, acc_o);
    chk("drain_ready_rise", {31'd0, lsu_ready}, 32'd1);
    chk("drain_first_addr", {27'd0, rf_waddr}, 32'd10);
    for (int i = 0; i < DEPTH + 1; i++)
      mstep("drain", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, acc_o);

    // reset mid-drain
    do_reset();
    for (int i = 0; i < 3; i++)
      mstep("prefill", 1'b1, 5'd1, 32'h77, 1'b1, 5'(20 + i), 32'h200 + i, acc_o);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we",    {31'd0, rf_we}, 32'd0);
    chk("mid_rst_pend",  pend_mask, 32'd0);
    chk("mid_rst_ready", {31'd0, lsu_ready}, 32'd1);
    chk("mid_rst_stall", {31'd0, wb_stall}, 32'd0);
    chk("mid_rst_count", {29'd0, dut.count_r}, 32'd0);
    #2 rst_n = 1'b1;
    m_clear();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++)
      mstep("post_rst", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, acc_o);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      mstep("rand",
            1'($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom, acc_o);
    end
    m_check("rand_end");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
